vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 97 +++++++++
 tb/tb_vga_timing_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: free-running pixel/line counters, blanking,
// sync pulses delayed to match the downstream colour register, frame tracking.
module vga_timing_gen #(
  parameter int PIPE_DELAY  = 1,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  output logic [9:0]             DrawX,
  output logic [9:0]             DrawY,
  output logic                   blank,
  output logic                   hs,
  output logic                   vs,
  output logic                   sync,
  output logic                   frame_end,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;
  localparam logic [9:0] V_LAST   = 10'd524;

  logic [9:0]             hc_q, hc_d;
  logic [9:0]             vc_q, vc_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic                   line_end;
  logic                   hs_raw, vs_raw;

  always_comb begin
    line_end      = (hc_q == H_LAST);
    frame_end     = line_end && (vc_q == V_LAST);
    hc_d          = line_end ? 10'd0 : hc_q + 10'd1;
    vc_d          = vc_q;
    frame_count_d = frame_count_q;
    if (frame_end) begin
      vc_d          = 10'd0;
      frame_count_d = frame_count_q + FRAME_CNT_W'(1);
    end else if (line_end) begin
      vc_d = vc_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      frame_count_q <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign frame_count = frame_count_q;
  assign sync        = 1'b0;
  assign blank       = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign hs_raw      = !((hc_q >= H_SYNC_S) && (hc_q <= H_SYNC_E));
  assign vs_raw      = !((vc_q >= V_SYNC_S) && (vc_q <= V_SYNC_E));

  // Sync delay chain; stage 0 takes the raw pulse, the last stage drives the pin.
  if (PIPE_DELAY == 0) begin : g_no_dly
    assign hs = hs_raw;
    assign vs = vs_raw;
  end else begin : g_dly
    logic [PIPE_DELAY-1:0] hs_dly_q, hs_dly_d;
    logic [PIPE_DELAY-1:0] vs_dly_q, vs_dly_d;

    always_comb begin
      hs_dly_d    = hs_dly_q << 1;
      vs_dly_d    = vs_dly_q << 1;
      hs_dly_d[0] = hs_raw;
      vs_dly_d[0] = vs_raw;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_dly_q <= '1;
        vs_dly_q <= '1;
      end else begin
        hs_dly_q <= hs_dly_d;
        vs_dly_q <= vs_dly_d;
      end
    end

    assign hs = hs_dly_q[PIPE_DELAY-1];
    assign vs = vs_dly_q[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (sync delay 1/0/3) run in
// lockstep against a pixel-index reference model; a monitor checks every cycle.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] dx_a, dy_a, dx_b, dy_b, dx_c, dy_c;
  logic       bl_a, hs_a, vs_a, sy_a, fe_a;
  logic       bl_b, hs_b, vs_b, sy_b, fe_b;
  logic       bl_c, hs_c, vs_c, sy_c, fe_c;
  logic [7:0] fc_a;
  logic [1:0] fc_b, fc_c;

  vga_timing_gen #(.PIPE_DELAY(1), .FRAME_CNT_W(8)) dut_a (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(dx_a), .DrawY(dy_a), .blank(bl_a),
    .hs(hs_a), .vs(vs_a), .sync(sy_a), .frame_end(fe_a), .frame_count(fc_a));
  vga_timing_gen #(.PIPE_DELAY(0), .FRAME_CNT_W(2)) dut_b (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(dx_b), .DrawY(dy_b), .blank(bl_b),
    .hs(hs_b), .vs(vs_b), .sync(sy_b), .frame_end(fe_b), .frame_count(fc_b));
  vga_timing_gen #(.PIPE_DELAY(3), .FRAME_CNT_W(2)) dut_c (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(dx_c), .DrawY(dy_c), .blank(bl_c),
    .hs(hs_c), .vs(vs_c), .sync(sy_c), .frame_end(fe_c), .frame_count(fc_c));

  typedef struct {
    int x;
    int y;
    bit blank;
    bit hs_a, hs_b, hs_c;
    bit vs_a, vs_b, vs_c;
    bit fe;
    int frames;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: linear pixel index within the frame plus a history of raw syncs.
  int   p;
  int   frames;
  bit   hist_hs[$];
  bit   hist_vs[$];
  logic [9:0] fy;

  function automatic bit raw_hs(int x);
    return !(x >= 656 && x <= 751);
  endfunction

  function automatic bit raw_vs(int y);
    return !(y >= 490 && y <= 491);
  endfunction

  task automatic model_reset();
    p       = 0;
    frames  = 0;
    hist_hs = '{1'b1, 1'b1, 1'b1, 1'b1};
    hist_vs = '{1'b1, 1'b1, 1'b1, 1'b1};
  endtask

  task automatic model_step();
    p = p + 1;
    if (p == 420000) begin
      p      = 0;
      frames = frames + 1;
    end
    hist_hs.push_front(raw_hs(p % 800));
    hist_vs.push_front(raw_vs(p / 800));
    void'(hist_hs.pop_back());
    void'(hist_vs.pop_back());
  endtask

  task automatic push_expect();
    exp_t e;
    e.x      = p % 800;
    e.y      = p / 800;
    e.blank  = (e.x < 640) && (e.y < 480);
    e.hs_a   = hist_hs[1];
    e.hs_b   = hist_hs[0];
    e.hs_c   = hist_hs[3];
    e.vs_a   = hist_vs[1];
    e.vs_b   = hist_vs[0];
    e.vs_c   = hist_vs[3];
    e.fe     = (p == 419999);
    e.frames = frames;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // One clock: the model advances if the DUTs saw reset high at the edge.
  task automatic tick(input bit rst_val);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    rst_n = rst_val;
    if (!rst_n) model_reset();
    push_expect();
  endtask

  task automatic run_to_x(input int tx);
    while (p % 800 != tx) tick(1'b1);
  endtask

  // Jump the line counter so late lines and frame ends are reached in a few
  // thousand cycles; the force spans one edge where vc holds its value anyway.
  task force_y(input int ny);
    fy = 10'(ny);
    force dut_a.vc_q = fy;
    force dut_b.vc_q = fy;
    force dut_c.vc_q = fy;
    void'(q.pop_back());
    p = ny * 800 + (p % 800);
    hist_vs[0] = raw_vs(ny);
    push_expect();
    tick(1'b1);
    release dut_a.vc_q;
    release dut_b.vc_q;
    release dut_c.vc_q;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("DrawX_a", 32'(dx_a), 32'(e.x));
        chk("DrawY_a", 32'(dy_a), 32'(e.y));
        chk("blank_a", 32'(bl_a), 32'(e.blank));
        chk("hs_a",    32'(hs_a), 32'(e.hs_a));
        chk("vs_a",    32'(vs_a), 32'(e.vs_a));
        chk("sync_a",  32'(sy_a), 32'd0);
        chk("fend_a",  32'(fe_a), 32'(e.fe));
        chk("fcnt_a",  32'(fc_a), 32'(e.frames % 256));
        chk("DrawX_b", 32'(dx_b), 32'(e.x));
        chk("DrawY_b", 32'(dy_b), 32'(e.y));
        chk("blank_b", 32'(bl_b), 32'(e.blank));
        chk("hs_b",    32'(hs_b), 32'(e.hs_b));
        chk("vs_b",    32'(vs_b), 32'(e.vs_b));
        chk("sync_b",  32'(sy_b), 32'd0);
        chk("fend_b",  32'(fe_b), 32'(e.fe));
        chk("fcnt_b",  32'(fc_b), 32'(e.frames % 4));
        chk("DrawX_c", 32'(dx_c), 32'(e.x));
        chk("DrawY_c", 32'(dy_c), 32'(e.y));
        chk("blank_c", 32'(bl_c), 32'(e.blank));
        chk("hs_c",    32'(hs_c), 32'(e.hs_c));
        chk("vs_c",    32'(vs_c), 32'(e.vs_c));
        chk("sync_c",  32'(sy_c), 32'd0);
        chk("fend_c",  32'(fe_c), 32'(e.fe));
        chk("fcnt_c",  32'(fc_c), 32'(e.frames % 4));
      end
    end
  end

  initial begin : driver
    int prev;
    model_reset();
    repeat (3) tick(1'b0);
    tick(1'b1);
    // First two lines: counter stepping, blanking, horizontal sync edges.
    repeat (1699) tick(1'b1);
    // Vertical sync region.
    run_to_x($urandom_range(20, 600));
    force_y(488);
    repeat (4 * 800) tick(1'b1);
    // Five frame ends, exercising the narrow frame counter wrap.
    for (int f = 0; f < 5; f++) begin
      run_to_x($urandom_range(20, 700));
      force_y(523);
      prev = frames;
      for (int k = 0; k < 1700 && frames == prev; k++) tick(1'b1);
      repeat ($urandom_range(1, 40)) tick(1'b1);
    end
    // Asynchronous reset between edges at (300,200).
    run_to_x($urandom_range(20, 250));
    force_y(200);
    run_to_x(300);
    rst_n = 1'b0;
    model_reset();
    void'(q.pop_back());
    push_expect();
    repeat ($urandom_range(1, 3)) tick(1'b0);
    tick(1'b1);
    repeat (900) tick(1'b1);
    // Random short reset pulses mid-line.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(5, 300)) tick(1'b1);
      tick(1'b0);
      repeat ($urandom_range(0, 2)) tick(1'b0);
      tick(1'b1);
    end
    repeat (50) tick(1'b1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
